// File: rtl/alu_seq.sv
// alu_seq: registered accumulator ALU with a valid/ready operation channel
// and a valid/ready result channel.
//
// Single-cycle ops (pass, add, sub, dec, clear, inc) register their result at
// the accept edge. A multiply runs as a WIDTH-iteration shift-add sequence, so
// the block contains no wide combinational multiplier. The result holds in HOLD
// until the consumer takes it.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   producer presents op/a/b
//   in_ready   block accepts an op this cycle (combinational)
//   op         opcode: 0 pass, 1 add, 2 sub, 3 mul, 4 dec, 5 clear, 6 inc, 7 pass
//   a, b       operands (a is the accumulator)
//   out_valid  result/z/c are valid
//   out_ready  consumer takes the result this cycle
//   result     low WIDTH bits of the operation
//   z          result == 0
//   c          carry / borrow / multiply overflow
//   busy       multiply in progress
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             z,
    output logic             c,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t               stateReg;
    logic [WIDTH-1:0]     resultReg;
    logic                 zReg;
    logic                 cReg;
    logic                 outValidReg;
    logic                 busyReg;
    logic [CW-1:0]        counterReg;
    logic [2*WIDTH-1:0]   mcandReg;
    logic [WIDTH-1:0]     mplierReg;
    logic [2*WIDTH-1:0]   productReg;

    logic                 accept;
    logic [WIDTH:0]       aluWide;
    logic [2*WIDTH-1:0]   productNext;

    assign in_ready  = rst_n && (stateReg == IDLE) && (!outValidReg || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = outValidReg;
    assign result    = resultReg;
    assign z         = zReg;
    assign c         = cReg;
    assign busy      = busyReg;

    // Single-cycle ops computed one bit wider; the top bit is carry out for
    // add/inc and borrow for sub/dec (two's-complement wrap of WIDTH+1 bits).
    always_comb begin
        aluWide = '0;
        case (op)
            3'd1:    aluWide = {1'b0, a} + {1'b0, b};
            3'd2:    aluWide = {1'b0, a} - {1'b0, b};
            3'd4:    aluWide = {1'b0, a} - (WIDTH + 1)'(1);
            3'd5:    aluWide = '0;
            3'd6:    aluWide = {1'b0, a} + (WIDTH + 1)'(1);
            default: aluWide = {1'b0, a};
        endcase
        if (op == 3'd0 || op == 3'd7) begin
            aluWide[WIDTH] = 1'b0;
        end
    end

    // One shift-add step: add the shifted multiplicand when the current
    // multiplier bit is set.
    assign productNext = productReg + (mplierReg[0] ? mcandReg : '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateReg    <= IDLE;
            resultReg   <= '0;
            zReg        <= 1'b0;
            cReg        <= 1'b0;
            outValidReg <= 1'b0;
            busyReg     <= 1'b0;
            counterReg  <= '0;
            mcandReg    <= '0;
            mplierReg   <= '0;
            productReg  <= '0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (accept) begin
                        if (op == 3'd3) begin
                            mcandReg    <= {{WIDTH{1'b0}}, a};
                            mplierReg   <= b;
                            productReg  <= '0;
                            counterReg  <= CW'(WIDTH);
                            busyReg     <= 1'b1;
                            outValidReg <= 1'b0;
                            stateReg    <= MUL;
                        end else begin
                            resultReg   <= aluWide[WIDTH-1:0];
                            zReg        <= (aluWide[WIDTH-1:0] == '0);
                            cReg        <= aluWide[WIDTH];
                            outValidReg <= 1'b1;
                        end
                    end else if (out_ready) begin
                        outValidReg <= 1'b0;
                    end
                end
                MUL: begin
                    productReg <= productNext;
                    mcandReg   <= mcandReg << 1;
                    mplierReg  <= mplierReg >> 1;
                    counterReg <= counterReg - CW'(1);
                    // Last iteration: publish straight from the final sum.
                    if (counterReg == CW'(1)) begin
                        resultReg   <= productNext[WIDTH-1:0];
                        cReg        <= |productNext[2*WIDTH-1:WIDTH];
                        zReg        <= (productNext[WIDTH-1:0] == '0);
                        outValidReg <= 1'b1;
                        busyReg     <= 1'b0;
                        stateReg    <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        outValidReg <= 1'b0;
                        stateReg    <= IDLE;
                    end
                end
                default: stateReg <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, parametrised successor to the accumulator-datapath ALU in the single-core matrix-multiply processor. It takes one operation per valid/ready handshake, then returns the result with zero and carry/overflow flags on a valid/ready output channel. Single-cycle ops (add, sub, inc, dec, clear, pass) have a 1-cycle latency. Multiply is a WIDTH-iteration shift-add sequence, so no wide combinational multiplier is needed. It sits between the control unit and the AC register: `a` is AC and `b` is the selected operand register.

## Interface
- WIDTH, 16, datapath width in bits; must be ≥ 2.
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- in_valid  in  1  an operation is presented on op/a/b.
- in_ready  out  1  the block accepts an op this cycle; combinational.
- op  in  3  opcode:
  - 0 pass a
  - 1 a+b
  - 2 a−b
  - 3 a×b
  - 4 a−1
  - 5 clear
  - 6 a+1
  - 7 reserved, behaves as pass
- a  in  WIDTH  operand 1 (AC).
- b  in  WIDTH  operand 2; ignored by ops 0, 4, 5, 6, 7.
- out_valid  out  1  result/z/c are valid.
- out_ready  in  1  the consumer takes the result this cycle.
- result  out  WIDTH  low WIDTH bits of the operation.
- z  out  1  result == 0.
- c  out  1  carry/borrow/overflow flag (see Operation).
- busy  out  1  a multiply is in progress.

## Operation
- Accept:
  - An op is accepted when in_valid && in_ready on a rising edge.
  - op, a and b are captured at accept; later input changes have no effect.
  - in_ready = rst_n && (state==IDLE) && (!out_valid || out_ready).
- States: IDLE, MUL, HOLD.
- IDLE:
  - Accepted op ≠ 3: result, z and c are registered at the accept edge; out_valid=1 next cycle; state stays IDLE.
  - Accepted op = 3: load the multiplicand into a 2·WIDTH register, the multiplier shift register with b, the product accumulator with 0 and the iteration counter with WIDTH; go to MUL; busy=1.
- MUL:
  - Each cycle: if the multiplier LSB = 1, add the multiplicand to the product (2·WIDTH-bit add).
  - Then shift the multiplicand left by 1 and the multiplier right by 1, and decrement the counter.
  - When the counter reaches 0:
    - result = product[WIDTH−1:0];
    - c = |product[2·WIDTH−1:WIDTH] (overflow);
    - z = result==0;
    - out_valid=1; go to HOLD; busy=0.
  - in_ready=0 throughout MUL.
- HOLD: wait for out_ready, then go to IDLE. in_ready=0 in HOLD, so a new op is accepted no earlier than the cycle after HOLD exits.
- Output channel:
  - result, z and c are stable while out_valid=1 && out_ready=0.
  - out_valid clears on the edge where out_ready=1, unless a new single-cycle op is accepted on that same edge; in that case out_valid stays 1 and the new values load.
- Flag rules (computed WIDTH+1 bits wide; result is the low WIDTH bits):
  - add/inc: c = carry out.
  - sub/dec: c = borrow (a < subtrahend).
  - clear: result=0, z=1, c=0.
  - pass/reserved: result=a, c=0.
  - z = (result==0) for every op.
- Wrap-around:
  - dec of 0 gives all-ones with c=1.
  - inc of all-ones gives 0 with z=1, c=1.

## Timing
- Reset values (rst_n low at a rising edge): state IDLE, result 0, z 0, c 0, out_valid 0, busy 0, counter 0. in_ready=0 while rst_n=0.
- Single-cycle op latency:
  - Accept at edge N gives out_valid=1 after edge N.
  - Throughput is 1 op/clock when out_ready is held high.
- Multiply latency:
  - Accept at edge N gives out_valid=1 after edge N+WIDTH (16 cycles for WIDTH=16).
  - The next accept is possible at edge N+WIDTH+2 at the earliest.
- Reset mid-multiply aborts immediately: all state returns to its reset value, and no out_valid is produced for the aborted op.
- in_valid while in_ready=0: the op is not captured; it must be held by the producer.
- out_ready while out_valid=0: no effect.

## Test plan
- Add wrap: after reset, op=1, a=16'hFFFF, b=16'h0001 accepted → next cycle result=16'h0000, z=1, c=1, out_valid=1.
- Decrement boundaries, back-to-back with out_ready=1:
  - op=4 a=1 → result 0, z=1, c=0;
  - op=4 a=0 → next cycle result 16'hFFFF, z=0, c=1.
- Multiply:
  - op=3, a=16'h0012, b=16'h0034 → busy 16 cycles, then result=16'h03A8, z=0, c=0, with out_valid exactly 16 cycles after accept.
  - a=16'h0100, b=16'h0100 → result 0, z=1, c=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after op=2, a=5, b=7 → result=16'hFFFE, c=1 held stable; in_ready=0; a new in_valid op is not captured.
  - Raise out_ready → out_valid drops the next cycle.
- Reset mid-multiply: pull rst_n low 8 cycles into a multiply → next cycle out_valid=0, busy=0, result=0, in_ready=1 after rst_n returns high; no stale result appears.
- Clear and pass: op=5 with any a/b → result 0, z=1, c=0; op=7, a=16'h1234 → result 16'h1234, z=0, c=0.
